adc_drp_scheduler: RTL and testbench
====================================

ADC_DRP_SCHEDULER -- requirements
Module: adc_drp_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the XADC DRP read port (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before abort (used only under ADC_SCHED_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: single system clock, 100 MHz, shared with the XADC dclk_in.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NUM_REQ: per-requester read request, level, held until its rsp_valid.
REQ-006 SHALL have port req_addr, input, NUM_REQ x 7: per-requester DRP address.
REQ-007 SHALL have port gnt, output, NUM_REQ: one-hot grant, pulsed for one cycle when the DRP read is issued.
REQ-008 SHALL have port rsp_valid, output, NUM_REQ: one-hot one-cycle response strobe.
REQ-009 SHALL have port rsp_data, output, 16: returned DRP data, valid while any rsp_valid bit is high.
REQ-010 SHALL have port rsp_err, output, 1: timeout flag, qualified by rsp_valid.
REQ-011 SHALL have ports den (output, 1), daddr (output, 7), dwe (output, 1, constant 0), drdy (input, 1), do_in (input, 16): DRP master side.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any req bit is high, SHALL select a winner round-robin, starting at (last_winner+1) mod NUM_REQ, latch the winner's index and req_addr, and go to ISSUE the next cycle.
REQ-015 ISSUE: SHALL drive den=1, daddr=latched address and gnt[winner]=1 for exactly one cycle, then go to WAIT.
REQ-016 WAIT: on drdy=1, SHALL register do_in into rsp_data and go to RESP.
REQ-017 RESP: SHALL assert rsp_valid[winner] for one cycle, update last_winner to winner, and return to IDLE.
REQ-018 Latency: with req sampled in IDLE at cycle 0, den SHALL be asserted at cycle 1; drdy at cycle k SHALL produce rsp_valid at cycle k+1.
REQ-019 A requester that drops req after grant SHALL still receive its rsp_valid; the transaction SHALL NOT be cancelled.
REQ-020 drdy asserted outside WAIT SHALL be ignored and SHALL NOT alter rsp_data.
REQ-021 A new request SHALL NOT be accepted in RESP; the earliest next ISSUE SHALL follow RESP by 2 cycles (IDLE, ISSUE).
REQ-022 With all requests continuously high, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no requester SHALL wait more than NUM_REQ-1 transactions.
REQ-023 rsp_data SHALL hold its last value between responses.

Reset
REQ-024 On reset low, SHALL go to IDLE immediately and drive den=0, dwe=0, daddr=0, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, with last_winner=NUM_REQ-1 so that requester 0 wins first.
REQ-025 A reset asserted mid-transaction SHALL abandon that transaction with no response; a late drdy after reset release SHALL be ignored per REQ-020.

Configuration
REQ-026 Macro ADC_SCHED_TIMEOUT_EN defined: a WAIT cycle counter SHALL run; after TIMEOUT_CYCLES WAIT cycles without drdy, the FSM SHALL go to RESP with rsp_data=16'h0000 and rsp_err=1.
REQ-027 Macro ADC_SCHED_TIMEOUT_EN not defined: no counter SHALL be built, WAIT SHALL last until drdy, and rsp_err SHALL be constant 0.

Structure
REQ-028 Package adc_sched_pkg SHALL hold the state enum, XADC address constants (ADDR_TEMP=7'h00, ADDR_VAUX15=7'h1F) and the DRP data width constant.
REQ-029 Round-robin selection SHALL be implemented in a sub-module rr_arbiter (request vector plus last_winner in; one-hot winner and valid out), purely combinational.

Verification
REQ-030 Single request: req[2]=1, addr 7'h1F; drdy at 3 cycles after den with do_in=16'hA5C0 -> gnt[2] pulse, den one cycle with daddr=7'h1F, rsp_valid[2] with rsp_data=16'hA5C0 one cycle after drdy.
REQ-031 Fairness: req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Drop after grant: req[1] falls the cycle after gnt[1] -> rsp_valid[1] still pulses; next grant goes to another active requester.
REQ-033 Spurious drdy in IDLE with do_in=16'hFFFF -> rsp_data unchanged, no rsp_valid.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=10): no drdy -> rsp_valid with rsp_err=1 and rsp_data=0 after 10 WAIT cycles; macro undefined -> busy stays high.
REQ-035 Reset low during WAIT -> all outputs return to reset values asynchronously; after release, req=4'b1000 is granted to requester 3 only, and req=4'b1111 is granted to requester 0 first.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
// Shared types and constants for the XADC DRP read scheduler.
//   state_t     : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   DRP_DATA_W  : width of DRP read data
//   DRP_ADDR_W  : width of DRP address
//   ADDR_TEMP   : XADC on-chip temperature status register
//   ADDR_VAUX15 : XADC VAUX15 status register
// ---------------------------------------------------------------------------
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DRP_DATA_W = 16;
    localparam int DRP_ADDR_W = 7;

    localparam logic [DRP_ADDR_W-1:0] ADDR_TEMP   = 7'h00;
    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX15 = 7'h1F;

endpackage

// File: rtl/adc_drp_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at
// (last_winner + 1) mod NUM_REQ and wraps, so the previous winner has the
// lowest priority.
// Ports:
//   req         in  [NUM_REQ-1:0] request vector
//   last_winner in  [IDX_W-1:0]   index of the previously served requester
//   winner      out [NUM_REQ-1:0] one-hot selected requester
//   valid       out               any request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_winner) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// adc_drp_scheduler
// Shares the XADC DRP read port between NUM_REQ requesters. One read is in
// flight at a time; requesters are served round-robin.
// Optional feature: define ADC_SCHED_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES WAIT cycles without drdy (rsp_data=0, rsp_err=1).
// Ports:
//   clk        in   system clock (also XADC dclk_in)
//   reset      in   asynchronous active-low reset
//   req        in   per-requester level request, held until its rsp_valid
//   req_addr   in   per-requester DRP address
//   gnt        out  one-hot, one-cycle pulse when the read is issued
//   rsp_valid  out  one-hot, one-cycle response strobe
//   rsp_data   out  last DRP read data (held between responses)
//   rsp_err    out  timeout flag, qualified by rsp_valid
//   den/daddr/dwe  out  DRP master controls (dwe tied low)
//   drdy/do_in     in   DRP read handshake and data
//   busy       out  high whenever not IDLE
// ---------------------------------------------------------------------------
module adc_drp_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0][DRP_ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DRP_DATA_W-1:0]                rsp_data,
    output logic                                 rsp_err,
    output logic                                 den,
    output logic [DRP_ADDR_W-1:0]                daddr,
    output logic                                 dwe,
    input  logic                                 drdy,
    input  logic [DRP_DATA_W-1:0]                do_in,
    output logic                                 busy
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        last_winner;
    logic [IDX_W-1:0]        winner_idx;
    logic [IDX_W-1:0]        arb_idx;
    logic [NUM_REQ-1:0]      arb_winner;
    logic                    arb_valid;
    logic [NUM_REQ-1:0]      winner_oh;
    logic [DRP_ADDR_W-1:0]   addr_q;
    logic                    timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (req),
        .last_winner (last_winner),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_winner[i]) arb_idx = IDX_W'(i);
        end
    end

    always_comb begin
        winner_oh             = '0;
        winner_oh[winner_idx] = 1'b1;
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counts completed WAIT cycles; cleared whenever we are not waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             wait_cnt <= '0;
        else if (state != WAIT) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == WAIT) && !drdy && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        err_q <= 1'b0;
        else if (state == WAIT && drdy)    err_q <= 1'b0;
        else if (timeout_hit)              err_q <= 1'b1;
    end

    assign rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        den       = 1'b0;
        daddr     = '0;
        gnt       = '0;
        rsp_valid = '0;
        case (state)
            IDLE:  if (arb_valid) state_nxt = ISSUE;
            ISSUE: begin
                den       = 1'b1;
                daddr     = addr_q;
                gnt       = winner_oh;
                state_nxt = WAIT;
            end
            WAIT:  if (drdy || timeout_hit) state_nxt = RESP;
            RESP: begin
                rsp_valid = winner_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dwe  = 1'b0;
    assign busy = (state != IDLE);

    // Winner/address are captured only in IDLE, so a requester dropping req
    // after grant cannot disturb the transaction in flight. rsp_data only
    // moves in WAIT, which makes drdy elsewhere harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_winner <= LAST_INIT;
            winner_idx  <= '0;
            addr_q      <= '0;
            rsp_data    <= '0;
        end else begin
            if (state == IDLE && arb_valid) begin
                winner_idx <= arb_idx;
                addr_q     <= req_addr[arb_idx];
            end
            if (state == WAIT) begin
                if (drdy)             rsp_data <= do_in;
                else if (timeout_hit) rsp_data <= '0;
            end
            if (state == RESP) last_winner <= winner_idx;
        end
    end

endmodule

// File: tb/tb_adc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_drp_scheduler
// Scoreboard bench for adc_drp_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=10).
// Expected responses are queued when drdy is driven and popped when
// rsp_valid appears. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_adc_drp_scheduler;
    import adc_sched_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      req = '0;
    logic [3:0][6:0] req_addr = '0;
    logic [3:0]      gnt;
    logic [3:0]      rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic            den;
    logic [6:0]      daddr;
    logic            dwe;
    logic            drdy = 1'b0;
    logic [15:0]     do_in = '0;
    logic            busy;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          model_last = 3;
    logic [15:0] model_data = '0;

    adc_drp_scheduler #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .den       (den),
        .daddr     (daddr),
        .dwe       (dwe),
        .drdy      (drdy),
        .do_in     (do_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [3:0] g, output int n);
        g = '0;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (gnt !== 4'b0000) begin
                g = gnt;
                n = i;
                return;
            end
        end
    endtask

    task automatic respond(input logic [15:0] data, input int d);
        repeat (d) step();
        drdy  = 1'b1;
        do_in = data;
        step();
        drdy  = 1'b0;
        do_in = '0;
    endtask

    task automatic push_exp(input int idx, input logic [15:0] data, input logic err);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
        model_last = idx;
        model_data = data;
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        e  = '0;
        ok = (exp_q.size() != 0);
        if (ok) e = exp_q.pop_front();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_last = 3;
        model_data = '0;
        exp_q.delete();
    endtask

    function automatic int rr_next(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({den, dwe, daddr, gnt, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: den=%b dwe=%b daddr=%h gnt=%b busy=%b want all 0", den, dwe, daddr, gnt, busy);
        end
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_err} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b data=%h err=%b want all 0", rsp_valid, rsp_data, rsp_err);
        end
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        logic [3:0] g;
        int         n;
        exp_t       e;
        bit         ok;
        req_addr[2] = ADDR_VAUX15;
        req = 4'b0100;
        wait_gnt(g, n);
        n_cmp++;
        if (n !== 1 || g !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_gnt: gnt=%b after %0d cycles want 0100 after 1", g, n);
        end
        n_cmp++;
        if ({den, daddr, dwe, busy} !== {1'b1, 7'h1F, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_drp: den=%b daddr=%h dwe=%b busy=%b want 1 1f 0 1", den, daddr, dwe, busy);
        end
        step();
        n_cmp++;
        if ({den, gnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_pulse: den=%b gnt=%b want 0 0000", den, gnt);
        end
        step();
        step();
        drdy  = 1'b1;
        do_in = 16'hA5C0;
        push_exp(2, 16'hA5C0, 1'b0);
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early_rsp: rsp_valid=%b want 0000", rsp_valid);
        end
        step();
        drdy  = 1'b0;
        do_in = '0;
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b data=%h err=%b want idx %0d data %h err %b", rsp_valid, rsp_data, rsp_err, e.idx, e.data, e.err);
        end
        req = 4'b0000;
        step();
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_data !== model_data || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: valid=%b data=%h busy=%b want 0000 %h 0", rsp_valid, rsp_data, busy, model_data);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  g;
        int          n;
        exp_t        e;
        bit          ok;
        logic [15:0] data;
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i] = 7'(8'h10 + i);
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_gnt(g, n);
            n_cmp++;
            if (g !== 4'(1 << (t % 4)) || daddr !== 7'(8'h10 + (t % 4))) begin
                n_fail++;
                $display("FAIL fair_gnt%0d: gnt=%b daddr=%h want %b %h", t, g, daddr, 4'(1 << (t % 4)), 7'(8'h10 + (t % 4)));
            end
            n_cmp++;
            if (n !== ((t == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL fair_gap%0d: grant after %0d cycles want %0d", t, n, (t == 0) ? 1 : 2);
            end
            data = 16'(16'hC000 + t * 16'h0111);
            push_exp(t % 4, data, 1'b0);
            respond(data, 1 + (t % 3));
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL fair_rsp%0d: valid=%b data=%h err=%b want idx %0d data %h", t, rsp_valid, rsp_data, rsp_err, e.idx, e.data);
            end
            if (t == 7) req = 4'b0000;
        end
        step();
    endtask

    task automatic test_drop_after_grant();
        logic [3:0] g;
        int         n;
        int         w;
        exp_t       e;
        bit         ok;
        req = 4'b1010;
        w = rr_next(req, model_last);
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'(1 << w)) begin
            n_fail++;
            $display("FAIL drop_gnt1: gnt=%b want %b", g, 4'(1 << w));
        end
        step();
        req = 4'b1000;
        push_exp(w, 16'h1111, 1'b0);
        respond(16'h1111, 0);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL drop_rsp1: valid=%b data=%h want idx %0d data %h", rsp_valid, rsp_data, e.idx, e.data);
        end
        w = rr_next(req, model_last);
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'(1 << w) || w !== 3) begin
            n_fail++;
            $display("FAIL drop_gnt3: gnt=%b want %b", g, 4'(1 << w));
        end
        push_exp(w, 16'h3333, 1'b0);
        respond(16'h3333, 2);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL drop_rsp3: valid=%b data=%h want idx %0d data %h", rsp_valid, rsp_data, e.idx, e.data);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_spurious_drdy();
        drdy  = 1'b1;
        do_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 4'b0000 || rsp_data !== model_data || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious%0d: valid=%b data=%h busy=%b want 0000 %h 0", i, rsp_valid, rsp_data, busy, model_data);
            end
        end
        drdy  = 1'b0;
        do_in = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        int         n;
        exp_t       e;
        bit         ok;
        req_addr[2] = ADDR_TEMP;
        req = 4'b0100;
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_gnt: gnt=%b want 0100", g);
        end
        step();
        step();
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if ({den, daddr, gnt, rsp_valid, busy, dwe} !== 17'h0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: den=%b daddr=%h gnt=%b valid=%b busy=%b data=%h err=%b want all 0", den, daddr, gnt, rsp_valid, busy, rsp_data, rsp_err);
        end
        req = 4'b0000;
        step();
        step();
        reset = 1'b1;
        model_last = 3;
        model_data = '0;
        drdy  = 1'b1;
        do_in = 16'h1234;
        step();
        step();
        drdy  = 1'b0;
        do_in = '0;
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_late_drdy: valid=%b data=%h busy=%b want 0000 0000 0", rsp_valid, rsp_data, busy);
        end
        req = 4'b1000;
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'b1000 || n !== 1) begin
            n_fail++;
            $display("FAIL mid_gnt3: gnt=%b after %0d want 1000 after 1", g, n);
        end
        push_exp(3, 16'h0BEE, 1'b0);
        respond(16'h0BEE, 1);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL mid_rsp3: valid=%b data=%h want idx %0d data %h", rsp_valid, rsp_data, e.idx, e.data);
        end
        req = 4'b0000;
        step();
        do_reset();
        req = 4'b1111;
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_first0: gnt=%b want 0001", g);
        end
        push_exp(0, 16'h0FAB, 1'b0);
        respond(16'h0FAB, 2);
        req = 4'b0000;
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL mid_rsp0: valid=%b data=%h want idx %0d data %h", rsp_valid, rsp_data, e.idx, e.data);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        int         n;
`ifdef ADC_SCHED_TIMEOUT_EN
        int         cnt;
        exp_t       e;
        bit         ok;
`else
        bit         stuck_ok;
`endif
        req_addr[0] = ADDR_TEMP;
        req = 4'b0001;
        wait_gnt(g, n);
        n_cmp++;
        if (g !== 4'(1 << rr_next(4'b0001, model_last))) begin
            n_fail++;
            $display("FAIL to_gnt: gnt=%b want 0001", g);
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        push_exp(0, 16'h0000, 1'b1);
        cnt = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (rsp_valid !== 4'b0000) begin
                cnt = i;
                break;
            end
        end
        n_cmp++;
        if (cnt !== 11) begin
            n_fail++;
            $display("FAIL to_latency: rsp after %0d cycles want 11", cnt);
        end
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data || rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL to_rsp: valid=%b data=%h err=%b want idx %0d data %h err %b", rsp_valid, rsp_data, rsp_err, e.idx, e.data, e.err);
        end
        req = 4'b0000;
        step();
`else
        stuck_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy !== 1'b1 || rsp_valid !== 4'b0000 || rsp_err !== 1'b0) stuck_ok = 1'b0;
        end
        n_cmp++;
        if (!stuck_ok) begin
            n_fail++;
            $display("FAIL to_stuck: busy=%b valid=%b err=%b want busy held, no response", busy, rsp_valid, rsp_err);
        end
        req = 4'b0000;
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_drop_after_grant();
        test_spurious_drdy();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
